// File: rtl/eth_parser_pkg.sv
// Shared L2 types for the RX parser and TX header builder: MAC/EtherType/descriptor
// types, standard header lengths and the TX header FSM state encoding.
package eth_parser_pkg;

  typedef logic [47:0] mac_addr_t;
  typedef logic [15:0] ethertype_t;

  typedef struct packed {
    mac_addr_t  dest_mac;
    mac_addr_t  src_mac;
    ethertype_t ethertype;
    logic       vlan_present;
    logic [11:0] vlan_id;
    logic [2:0] vlan_pcp;
    logic [15:0] payload_len;
  } eth_metadata_t;

  localparam logic [15:0] ETH_TPID_VLAN     = 16'h8100;
  localparam int          ETH_HDR_LEN       = 14;
  localparam int          ETH_VLAN_HDR_LEN  = 18;
  localparam int          ETH_MIN_FRAME_LEN = 60;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    PAD
  } tx_hdr_state_t;

endpackage

// File: rtl/eth_header_builder_hdr_byte_mux.sv
// Combinational pick of header byte[idx] from captured descriptor fields; zero latency,
// no flow control of its own (the caller holds idx stable while stalled).
module eth_hdr_byte_mux
  import eth_parser_pkg::*;
#(
  parameter logic [15:0] VLAN_TPID   = ETH_TPID_VLAN,
  parameter logic [2:0]  DEFAULT_PCP = 3'd0
) (
  input  mac_addr_t   dest_mac,
  input  mac_addr_t   src_mac,
  input  ethertype_t  ethertype,
  input  logic        vlan_present,
  input  logic [11:0] vlan_id,
  input  logic [4:0]  idx,
  output logic [7:0]  hdr_byte
);

  logic [143:0] hdr_vec;
  logic [143:0] hdr_shifted;

  // Header laid out MSB-first so byte[idx] is the top byte after a left shift.
  always_comb begin
    if (vlan_present) begin
      hdr_vec = {dest_mac, src_mac, VLAN_TPID, DEFAULT_PCP, 1'b0, vlan_id, ethertype};
    end else begin
      hdr_vec = {dest_mac, src_mac, ethertype, 32'h0};
    end
    hdr_shifted = hdr_vec << {idx, 3'b000};
    hdr_byte    = hdr_shifted[143:136];
  end

endmodule

// File: rtl/eth_header_builder.sv
// TX L2 header serialiser: MACs, optional 802.1Q tag, EtherType, payload pass-through, zero pad.
// First byte the cycle after the descriptor handshake; tx_ready stalls hold HDR/PAD bytes, pl_ready follows tx_ready.
module eth_header_builder
  import eth_parser_pkg::*;
#(
  parameter int          MIN_FRAME_LEN = ETH_MIN_FRAME_LEN,
  parameter bit          PAD_EN        = 1'b1,
  parameter logic [15:0] VLAN_TPID     = ETH_TPID_VLAN,
  parameter logic [2:0]  DEFAULT_PCP   = 3'd0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          meta_valid,
  output logic          meta_ready,
  input  eth_metadata_t meta_in,
  input  logic [7:0]    pl_data,
  input  logic          pl_valid,
  input  logic          pl_last,
  output logic          pl_ready,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          tx_sof,
  output logic          tx_eof,
  output logic [31:0]   frame_count
);

  localparam logic [16:0] MIN_LEN        = 17'(MIN_FRAME_LEN);
  localparam logic [15:0] PAD_LAST       = 16'(MIN_FRAME_LEN - 1);
  localparam logic [15:0] HDR_LAST_UNTAG = 16'(ETH_HDR_LEN - 1);
  localparam logic [15:0] HDR_LAST_TAG   = 16'(ETH_VLAN_HDR_LEN - 1);

  tx_hdr_state_t state;
  logic [15:0]   bcnt;
  mac_addr_t     dest_q;
  mac_addr_t     src_q;
  ethertype_t    etype_q;
  logic          vlan_q;
  logic [11:0]   vid_q;
  logic [7:0]    hdr_byte;
  logic          hdr_last;
  logic          need_pad;
  logic          unused_meta;

  assign unused_meta = ^{meta_in.vlan_pcp, meta_in.payload_len};
  assign hdr_last    = (bcnt == (vlan_q ? HDR_LAST_TAG : HDR_LAST_UNTAG));
  assign need_pad    = PAD_EN && (({1'b0, bcnt} + 17'd1) < MIN_LEN);

  eth_hdr_byte_mux #(
    .VLAN_TPID   (VLAN_TPID),
    .DEFAULT_PCP (DEFAULT_PCP)
  ) u_hdr_mux (
    .dest_mac     (dest_q),
    .src_mac      (src_q),
    .ethertype    (etype_q),
    .vlan_present (vlan_q),
    .vlan_id      (vid_q),
    .idx          (bcnt[4:0]),
    .hdr_byte     (hdr_byte)
  );

  always_comb begin
    meta_ready = 1'b0;
    pl_ready   = 1'b0;
    tx_valid   = 1'b0;
    tx_data    = 8'h00;
    tx_sof     = 1'b0;
    tx_eof     = 1'b0;
    case (state)
      IDLE: meta_ready = 1'b1;
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = hdr_byte;
        tx_sof   = (bcnt == 16'd0);
      end
      PAYLOAD: begin
        tx_valid = pl_valid;
        tx_data  = pl_data;
        pl_ready = tx_ready;
        // A short frame's last payload byte is not the frame's last byte.
        tx_eof   = pl_valid && pl_last && !need_pad;
      end
      PAD: begin
        tx_valid = 1'b1;
        tx_eof   = (bcnt == PAD_LAST);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      bcnt        <= '0;
      dest_q      <= '0;
      src_q       <= '0;
      etype_q     <= '0;
      vlan_q      <= 1'b0;
      vid_q       <= '0;
      frame_count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (meta_valid) begin
            dest_q  <= meta_in.dest_mac;
            src_q   <= meta_in.src_mac;
            etype_q <= meta_in.ethertype;
            vlan_q  <= meta_in.vlan_present;
            vid_q   <= meta_in.vlan_id;
            bcnt    <= '0;
            state   <= HDR;
          end
        end
        HDR: begin
          if (tx_ready) begin
            bcnt <= bcnt + 16'd1;
            if (hdr_last) state <= PAYLOAD;
          end
        end
        PAYLOAD: begin
          if (pl_valid && tx_ready) begin
            bcnt <= (bcnt == 16'hFFFF) ? bcnt : bcnt + 16'd1;
            if (pl_last) begin
              if (need_pad) begin
                state <= PAD;
              end else begin
                frame_count <= frame_count + 32'd1;
                state       <= IDLE;
              end
            end
          end
        end
        PAD: begin
          if (tx_ready) begin
            bcnt <= bcnt + 16'd1;
            if (tx_eof) begin
              frame_count <= frame_count + 32'd1;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_header_builder.sv
// Self-checking bench for eth_header_builder: frame-level byte model plus directed scenarios.
module tb_eth_header_builder;
  import eth_parser_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          meta_valid, meta_ready, pl_valid, pl_last, pl_ready;
  logic          tx_valid, tx_ready, tx_sof, tx_eof;
  eth_metadata_t meta_in;
  logic [7:0]    pl_data, tx_data;
  logic [31:0]   frame_count;
  logic          meta_ready1, pl_ready1, tx_valid1, tx_sof1, tx_eof1;
  logic [7:0]    tx_data1;
  logic [31:0]   frame_count1;

  eth_header_builder dut (
    .clk(clk), .rst(rst), .meta_valid(meta_valid), .meta_ready(meta_ready), .meta_in(meta_in),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last), .pl_ready(pl_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_sof(tx_sof),
    .tx_eof(tx_eof), .frame_count(frame_count)
  );

  eth_header_builder #(.PAD_EN(1'b0)) dut_nopad (
    .clk(clk), .rst(rst), .meta_valid(meta_valid), .meta_ready(meta_ready1), .meta_in(meta_in),
    .pl_data(pl_data), .pl_valid(pl_valid), .pl_last(pl_last), .pl_ready(pl_ready1),
    .tx_data(tx_data1), .tx_valid(tx_valid1), .tx_ready(tx_ready), .tx_sof(tx_sof1),
    .tx_eof(tx_eof1), .frame_count(frame_count1)
  );

  typedef struct { logic [7:0] d; bit sof; bit eof; bit pl; } exp_t;
  typedef struct { logic [7:0] d; bit last; } plb_t;

  eth_metadata_t meta_q[$];
  plb_t          pl_q[$];
  exp_t          exp_q[$];
  logic [7:0]    rx_q[$];

  int n_vec = 0, n_err = 0;
  bit busy = 1'b0;
  int model_fc = 0, byte_idx = 0, cyc = 0, eof_cyc = 0;
  int sof_gap = -1, eof_idx = -1, eof1_idx = -1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: a frame is header bytes, payload, then zeros up to 60 bytes.
  function automatic void add_frame(input mac_addr_t dst, input mac_addr_t src, input ethertype_t et,
                                    input bit vlan, input logic [11:0] vid, input int npl,
                                    input logic [7:0] base);
    eth_metadata_t m;
    logic [7:0]    hdr[$];
    exp_t          e;
    plb_t          p;
    int            total, padded;
    m = '0;
    m.dest_mac = dst; m.src_mac = src; m.ethertype = et;
    m.vlan_present = vlan; m.vlan_id = vid; m.vlan_pcp = 3'd5; m.payload_len = 16'(npl);
    meta_q.push_back(m);
    for (int i = 0; i < 6; i++) hdr.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) hdr.push_back(src[47-8*i -: 8]);
    if (vlan) begin
      hdr.push_back(8'h81); hdr.push_back(8'h00);
      hdr.push_back({4'h0, vid[11:8]}); hdr.push_back(vid[7:0]);
    end
    hdr.push_back(et[15:8]); hdr.push_back(et[7:0]);
    total  = hdr.size() + npl;
    padded = (total < 60) ? 60 : total;
    for (int i = 0; i < padded; i++) begin
      e.sof = (i == 0);
      e.eof = (i == padded - 1);
      e.pl  = (i >= hdr.size()) && (i < total);
      if (i < hdr.size()) e.d = hdr[i];
      else if (i < total) e.d = 8'(base + 8'(i - hdr.size()));
      else e.d = 8'h00;
      exp_q.push_back(e);
    end
    for (int i = 0; i < npl; i++) begin
      p.d = 8'(base + 8'(i));
      p.last = (i == npl - 1);
      pl_q.push_back(p);
    end
  endfunction

  initial begin : meta_drv
    bit hs;
    meta_valid = 1'b0; meta_in = '0;
    forever begin
      @(negedge clk); hs = !rst && meta_valid && meta_ready;
      @(posedge clk); #1;
      if (hs && meta_q.size() > 0) void'(meta_q.pop_front());
      meta_valid = (meta_q.size() > 0);
      if (meta_q.size() > 0) meta_in = meta_q[0];
    end
  end

  initial begin : pl_drv
    bit hs;
    pl_valid = 1'b0; pl_data = 8'h00; pl_last = 1'b0;
    forever begin
      @(negedge clk); hs = !rst && pl_valid && pl_ready;
      @(posedge clk); #1;
      if (hs && pl_q.size() > 0) void'(pl_q.pop_front());
      pl_valid = (pl_q.size() > 0);
      if (pl_q.size() > 0) begin pl_data = pl_q[0].d; pl_last = pl_q[0].last; end
      else begin pl_data = 8'h00; pl_last = 1'b0; end
    end
  end

  initial begin : compare
    exp_t       e;
    bit         stalled = 1'b0;
    logic [10:0] prev = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        meta_q.delete(); pl_q.delete(); exp_q.delete();
        busy = 1'b0; model_fc = 0; byte_idx = 0; stalled = 1'b0;
        continue;
      end
      chk("frame_count", frame_count, 64'(model_fc));
      chk("meta_ready", meta_ready, !busy);
      if (!busy || exp_q.size() == 0) begin
        chk("tx_valid_idle", tx_valid, 1'b0);
        chk("pl_ready_idle", pl_ready, 1'b0);
      end else if (exp_q[0].pl) begin
        chk("pl_ready_pass", pl_ready, tx_ready);
        chk("tx_valid_pass", tx_valid, pl_valid);
      end else begin
        chk("tx_valid_hdr_pad", tx_valid, 1'b1);
        chk("pl_ready_hdr_pad", pl_ready, 1'b0);
      end
      if (stalled) chk("stall_hold", {tx_valid, tx_data, tx_sof, tx_eof}, prev);
      if (tx_valid && tx_sof && !stalled) sof_gap = cyc - eof_cyc;
      if (tx_valid1 && tx_ready && tx_eof1) eof1_idx = byte_idx;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL extra_byte: got %0h expected no byte", tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_data", tx_data, e.d);
          chk("tx_sof", tx_sof, e.sof);
          chk("tx_eof", tx_eof, e.eof);
          if (e.sof) rx_q.delete();
          rx_q.push_back(tx_data);
          byte_idx++;
          if (e.eof) begin
            busy = 1'b0; byte_idx = 0; model_fc++; eof_cyc = cyc; eof_idx = rx_q.size() - 1;
          end
        end
      end
      if (meta_valid && meta_ready) busy = 1'b1;
      stalled = tx_valid && !tx_ready;
      prev = {tx_valid, tx_data, tx_sof, tx_eof};
    end
  end

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || meta_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    n_vec++;
    if (n >= budget) begin n_err++; $display("FAIL %s_timeout: got %0d cycles expected < %0d", name, n, budget); end
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    chk({name, "_tx_valid"}, tx_valid, 1'b0);
    chk({name, "_tx_sof"}, tx_sof, 1'b0);
    chk({name, "_tx_eof"}, tx_eof, 1'b0);
    chk({name, "_pl_ready"}, pl_ready, 1'b0);
    chk({name, "_tx_data"}, tx_data, 8'h00);
    chk({name, "_frame_count"}, frame_count, 32'd0);
    chk({name, "_meta_ready"}, meta_ready, 1'b1);
  endtask

  localparam mac_addr_t DST = 48'h001122334455;
  localparam mac_addr_t SRC = 48'h66778899AABB;

  initial begin : main
    int n;
    tx_ready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check_reset_state("reset");

    // Untagged, exactly minimum length.
    add_frame(DST, SRC, 16'h0800, 1'b0, 12'h0, 46, 8'h10);
    wait_idle("untagged", 1000);
    chk("t1_len", rx_q.size(), 60);
    chk("t1_b0", rx_q[0], 8'h00);
    chk("t1_b12", rx_q[12], 8'h08);
    chk("t1_b13", rx_q[13], 8'h00);
    chk("t1_eof_idx", eof_idx, 59);
    chk("t1_fc", frame_count, 32'd1);

    // Tagged.
    add_frame(DST, SRC, 16'h86DD, 1'b1, 12'h123, 100, 8'h01);
    wait_idle("tagged", 1000);
    chk("t2_len", rx_q.size(), 118);
    chk("t2_tag", {rx_q[12], rx_q[13], rx_q[14], rx_q[15]}, 32'h81000123);
    chk("t2_etype", {rx_q[16], rx_q[17]}, 16'h86DD);
    chk("t2_eof_idx", eof_idx, 117);

    // Short frame, padded on dut and unpadded on dut_nopad.
    eof1_idx = -1;
    add_frame(DST, SRC, 16'h0800, 1'b0, 12'h0, 10, 8'hA0);
    wait_idle("pad", 1000);
    chk("t3_len", rx_q.size(), 60);
    chk("t3_b23", rx_q[23], 8'hA9);
    chk("t3_b24", rx_q[24], 8'h00);
    chk("t3_b59", rx_q[59], 8'h00);
    chk("t3_eof_idx", eof_idx, 59);
    chk("t3_nopad_eof_idx", eof1_idx, 23);
    chk("t3_nopad_fc", frame_count1, 32'd3);

    // Backpressure: 5-cycle stall at byte 3, then toggling ready.
    add_frame(DST, SRC, 16'h0800, 1'b0, 12'h0, 46, 8'h40);
    n = 0;
    while (byte_idx < 3 && n < 200) begin @(posedge clk); #1; n++; end
    chk("t4_reach_byte3", byte_idx, 3);
    tx_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    for (int k = 0; k < 400 && (busy || exp_q.size() > 0); k++) begin
      tx_ready = ~tx_ready;
      @(posedge clk); #1;
    end
    tx_ready = 1'b1;
    wait_idle("backpressure", 200);
    chk("t4_len", rx_q.size(), 60);
    chk("t4_b3", rx_q[3], 8'h33);
    chk("t4_eof_idx", eof_idx, 59);

    // Back-to-back frames after a reset.
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_reset_state("reset2");
    add_frame(DST, SRC, 16'h0800, 1'b0, 12'h0, 46, 8'h50);
    add_frame(SRC, DST, 16'h0806, 1'b1, 12'hABC, 20, 8'h70);
    wait_idle("b2b", 2000);
    chk("t5_fc", frame_count, 32'd2);
    chk("t5_sof_gap", sof_gap, 2);
    chk("t5_tci", {rx_q[14], rx_q[15]}, 16'h0ABC);
    chk("t5_eof_idx", eof_idx, 59);

    // Reset in the middle of the payload.
    add_frame(DST, SRC, 16'h0800, 1'b0, 12'h0, 46, 8'h90);
    n = 0;
    while (byte_idx < 34 && n < 200) begin @(posedge clk); #1; n++; end
    chk("t6_reach_pl20", byte_idx, 34);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_tx_valid", tx_valid, 1'b0);
    chk("t6_pl_ready", pl_ready, 1'b0);
    chk("t6_tx_eof", tx_eof, 1'b0);
    chk("t6_fc", frame_count, 32'd0);
    chk("t6_meta_ready", meta_ready, 1'b1);
    add_frame(DST, SRC, 16'h0800, 1'b1, 12'h005, 30, 8'hC0);
    wait_idle("after_rst", 1000);
    chk("t6_len", rx_q.size(), 60);
    chk("t6_b0", rx_q[0], 8'h00);
    chk("t6_b47", rx_q[47], 8'hDD);
    chk("t6_fc_after", frame_count, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no completion expected finish before %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/eth_header_builder.md
Name: eth_header_builder

Overview:
Transmit-side counterpart of the receive parsing path. The block accepts one `eth_metadata_t` descriptor per frame and serialises the L2 header onto a byte stream: destination MAC, source MAC, an optional 802.1Q tag, then the EtherType. It then passes payload bytes through and zero-pads short frames up to the minimum length. It sits between the TX metadata source and the MAC byte interface.

Parameters:
- `MIN_FRAME_LEN`, 60: minimum frame length in bytes, excluding FCS; pad target.
- `PAD_EN`, 1: 1 enables zero padding; 0 ends the frame on the payload's last byte.
- `VLAN_TPID`, 16'h8100: TPID emitted when `vlan_present` is set.
- `DEFAULT_PCP`, 3'd0: PCP field of the emitted TCI; DEI is always 0.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `meta_valid`  in  1  descriptor valid.
- `meta_ready`  out  1  descriptor accepted when `meta_valid && meta_ready`.
- `meta_in`  in  `eth_metadata_t`  uses `dest_mac`, `src_mac`, `ethertype`, `vlan_present`, `vlan_id`; other fields are ignored.
- `pl_data`  in  8  payload byte.
- `pl_valid`  in  1  payload byte valid.
- `pl_last`  in  1  last payload byte of the frame.
- `pl_ready`  out  1  payload byte consumed when `pl_valid && pl_ready`.
- `tx_data`  out  8  output byte.
- `tx_valid`  out  1  output byte valid.
- `tx_ready`  in  1  output byte accepted when `tx_valid && tx_ready`.
- `tx_sof`  out  1  first byte of the frame; qualified by `tx_valid`.
- `tx_eof`  out  1  final byte of the frame; qualified by `tx_valid`.
- `frame_count`  out  32  frames completed; wraps modulo 2^32.

Behaviour:
- Interface decision: one clock, `clk`; reset `rst` is synchronous and active-high.
- Reset:
  - state = IDLE.
  - `tx_valid`, `tx_sof`, `tx_eof`, `pl_ready` = 0.
  - `tx_data` = 0.
  - `frame_count` = 0.
  - `meta_ready` = 1 (IDLE).
  - Metadata register and byte counter cleared.
- FSM states: IDLE, HDR, PAYLOAD, PAD.
- IDLE:
  - `meta_ready` = 1; `tx_valid` = 0; `pl_ready` = 0.
  - On `meta_valid`: register the descriptor and go to HDR.
  - `hdr_len` = 18 if `vlan_present`, else 14.
  - Byte counter `bcnt` (16 bit) = 0.
- HDR:
  - `tx_valid` = 1; `tx_data` = header byte[`bcnt`].
  - Header byte order:
    - Bytes 0-5: `dest_mac[47:40]` first.
    - Bytes 6-11: `src_mac[47:40]` first.
    - If tagged, bytes 12-15: `VLAN_TPID[15:8]`, `VLAN_TPID[7:0]`, `{DEFAULT_PCP, 1'b0, vlan_id[11:8]}`, `vlan_id[7:0]`.
    - Last two bytes: `ethertype[15:8]`, `ethertype[7:0]`.
  - `tx_sof` = 1 only when `bcnt` = 0.
  - On `tx_ready`, `bcnt` increments.
  - The byte at `hdr_len-1` accepted → PAYLOAD.
- PAYLOAD: combinational pass-through.
  - `tx_valid` = `pl_valid`; `tx_data` = `pl_data`; `pl_ready` = `tx_ready`.
  - `bcnt` increments per accepted byte and saturates at 16'hFFFF.
  - On an accepted `pl_last`:
    - If `PAD_EN` and `bcnt+1 < MIN_FRAME_LEN`: `tx_eof` = 0, go to PAD.
    - Otherwise: `tx_eof` = 1, `frame_count`++, go to IDLE.
- PAD:
  - `pl_ready` = 0; `tx_valid` = 1; `tx_data` = 8'h00.
  - `tx_eof` = 1 when `bcnt` = `MIN_FRAME_LEN-1`.
  - Accepted eof byte → `frame_count`++, go to IDLE.
- Latency: the first header byte is presented the cycle after the metadata handshake. There are no bubbles inside a frame when `tx_ready` = 1 and `pl_valid` = 1.
- Backpressure: while `tx_valid && !tx_ready`, `tx_data`/`tx_sof`/`tx_eof` hold stable in HDR/PAD. In PAYLOAD, stability follows from the upstream holding its byte.
- `meta_ready` is 0 outside IDLE. A new descriptor is accepted no earlier than the cycle after the eof handshake, so back-to-back frames have exactly one idle cycle.
- `pl_valid` in IDLE/HDR/PAD is ignored; `pl_ready` stays 0 there.
- A payload must carry at least one byte. A frame whose payload has no `pl_last` never terminates; this is upstream's responsibility.
- Reset mid-frame: the frame is abandoned without eof, `frame_count` is cleared, and the FSM returns to IDLE on the next edge.
- `rst` takes precedence over all handshakes in the same cycle.

Decomposition:
- Reuse `mac_addr_t`, `ethertype_t` and `eth_metadata_t` from `eth_parser_pkg`.
- Add to the package:
  - `ETH_TPID_VLAN` = 16'h8100.
  - `ETH_HDR_LEN` = 14.
  - `ETH_VLAN_HDR_LEN` = 18.
  - `ETH_MIN_FRAME_LEN` = 60.
  - Enum `tx_hdr_state_t` (IDLE, HDR, PAYLOAD, PAD).
- One natural sub-module, `eth_hdr_byte_mux`: combinational selection of header byte[`bcnt`] from the registered metadata plus `vlan_present`.

Test Plan:
- Untagged frame: `dest` 00:11:22:33:44:55, `src` 66:77:88:99:AA:BB, `ethertype` 0x0800, 46 payload bytes.
  - Expect 60 bytes; byte0 = 0x00 with `tx_sof`; bytes 12-13 = 08 00.
  - Byte 59 only carries `tx_eof`; no pad; `frame_count` = 1.
- Tagged frame: `vlan_id` 0x123, `ethertype` 0x86DD, 100 payload bytes.
  - Expect bytes 12-15 = 81 00 01 23 and 16-17 = 86 DD.
  - Total 118 bytes; eof on byte 117.
- Padding: untagged, 10 payload bytes.
  - `pl_last` is accepted at byte 23 with `tx_eof` = 0.
  - Bytes 24-59 = 0x00; eof on byte 59.
  - With `PAD_EN` = 0: eof on byte 23, 24 bytes total.
- Backpressure: `tx_ready` low for 5 cycles at `bcnt` = 3, then toggling every cycle.
  - `tx_data` stays stable while stalled.
  - Received byte sequence identical to the unstalled run; no loss or duplication.
- Back-to-back: `meta_valid` held high with a second descriptor during frame 1.
  - `meta_ready` = 0 until IDLE.
  - Second `tx_sof` appears 2 cycles after the frame-1 eof handshake.
  - `frame_count` = 2.
- Reset mid-payload: assert `rst` at payload byte 20.
  - Next cycle: `tx_valid`/`pl_ready`/`tx_eof` = 0, `frame_count` = 0, `meta_ready` = 1.
  - A subsequent frame is emitted correctly from byte 0.
